// File: rtl/stream_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_pkt_fifo : per-output packet FIFO with a FWFT valid/ready out  |
// | STREAM_PKT_FIFO_STORE_FWD_EN selects store-and-forward (default: cut) |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module stream_pkt_fifo #(
   parameter int  T_DATA_WIDTH = 8,
   parameter int  T_ID_WIDTH   = 1,
   parameter int  DEPTH        = 8,
   localparam int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [T_DATA_WIDTH-1:0] s_data_i,
   input  logic [T_ID_WIDTH-1:0]   s_id_i,
   input  logic                    s_last_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   output logic [T_DATA_WIDTH-1:0] m_data_o,
   output logic [T_ID_WIDTH-1:0]   m_id_o,
   output logic                    m_last_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [CNT_WIDTH-1:0]    level_o,
   output logic [CNT_WIDTH-1:0]    pkt_cnt_o
);
   localparam int PTR_WIDTH   = $clog2(DEPTH);
   localparam int ENTRY_WIDTH = T_ID_WIDTH + 1 + T_DATA_WIDTH;

   logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]   level_q, level_d;
   logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic                   push, pop, full, empty;

   assign full      = (level_q == CNT_WIDTH'(DEPTH));
   assign empty     = (level_q == '0);
   assign s_ready_o = !full;
   assign push      = s_valid_i && s_ready_o;
   assign pop       = m_valid_o && m_ready_i;
   assign level_o   = level_q;
   assign pkt_cnt_o = pkt_cnt_q;

   // Head entry falls through directly; it cannot change until rd_ptr moves.
   assign {m_id_o, m_last_o, m_data_o} = mem_q[rd_ptr_q];

`ifdef STREAM_PKT_FIFO_STORE_FWD_EN
   logic in_pkt_q, in_pkt_d;

   // The full escape lets an oversize packet drain; in_pkt keeps it flowing once started.
   assign m_valid_o = !empty && ((pkt_cnt_q != '0) || full || in_pkt_q);

   always_comb begin
      in_pkt_d = in_pkt_q;
      if (pop) in_pkt_d = !m_last_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_pkt_q <= 1'b0;
      else        in_pkt_q <= in_pkt_d;
   end
`else
   assign m_valid_o = !empty;
`endif

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      pkt_cnt_d = pkt_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + CNT_WIDTH'(1);
         2'b01:   level_d = level_q - CNT_WIDTH'(1);
         default: level_d = level_q;
      endcase
      case ({push && s_last_i, pop && m_last_o})
         2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_WIDTH'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         pkt_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   // Storage needs no reset: stale entries are never visible with level at zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {s_id_i, s_last_i, s_data_i};
   end
endmodule
`default_nettype wire
